// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Optional macro DIV_ZERO_TRAP_EN adds div_zero_exc and rejects divides by zero.
module hilo_muldiv_unit #(
   parameter int MUL_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  alu_control,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic [31:0] result_out,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        stall_req,
   output logic        done
`ifdef DIV_ZERO_TRAP_EN
   ,
   output logic        div_zero_exc
`endif
);

   localparam logic [5:0] OP_MFHI  = 6'd16;
   localparam logic [5:0] OP_MTHI  = 6'd17;
   localparam logic [5:0] OP_MFLO  = 6'd18;
   localparam logic [5:0] OP_MTLO  = 6'd19;
   localparam logic [5:0] OP_MULT  = 6'd24;
   localparam logic [5:0] OP_MULTU = 6'd25;
   localparam logic [5:0] OP_DIV   = 6'd26;
   localparam logic [5:0] OP_DIVU  = 6'd27;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DIV_FIX} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [63:0] prod;
   logic [31:0] quo, rem, dvs;
   logic        neg_q, neg_r;

   logic        in_set, accept, sgn, a_neg, b_neg, ge;
   logic [31:0] mag_a, mag_b;
   logic [63:0] prod_next;
   logic [32:0] shifted, diff;

   always_comb begin
      in_set = (alu_control >= OP_MFHI && alu_control <= OP_MTLO) ||
               (alu_control >= OP_MULT && alu_control <= OP_DIVU);
      accept = (state == IDLE) && start && !flush && in_set;
      // mult and div are the even codes; the odd ones are unsigned
      sgn    = ~alu_control[0];
      a_neg  = sgn & src_a[31];
      b_neg  = sgn & src_b[31];
      prod_next = {{32{a_neg}}, src_a} * {{32{b_neg}}, src_b};
      // negating 0x8000_0000 wraps to itself, which is the correct unsigned magnitude
      mag_a  = a_neg ? -src_a : src_a;
      mag_b  = b_neg ? -src_b : src_b;
      shifted = {rem, quo[31]};
      diff    = shifted - {1'b0, dvs};
      ge      = shifted >= {1'b0, dvs};
   end

   assign busy      = (state != IDLE);
   assign stall_req = start & busy & in_set;
   assign result_out = (alu_control == OP_MFHI) ? hi_out :
                       (alu_control == OP_MFLO) ? lo_out : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         prod   <= '0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi_out <= '0;
         lo_out <= '0;
         done   <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
         div_zero_exc <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
         div_zero_exc <= 1'b0;
`endif
         case (state)
            IDLE: if (accept) begin
               case (alu_control)
                  OP_MTHI: hi_out <= src_a;
                  OP_MTLO: lo_out <= src_a;
                  OP_MULT, OP_MULTU: begin
                     prod  <= prod_next;
                     cnt   <= 5'(MUL_LATENCY - 1);
                     state <= MUL;
                  end
                  OP_DIV, OP_DIVU: begin
`ifdef DIV_ZERO_TRAP_EN
                     if (src_b == 32'd0) begin
                        div_zero_exc <= 1'b1;
                     end else
`endif
                     begin
                        quo   <= mag_a;
                        rem   <= '0;
                        dvs   <= mag_b;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= 5'd31;
                        state <= DIV;
                     end
                  end
                  default: ;
               endcase
            end
            MUL: begin
               if (flush) begin
                  state <= IDLE;
               end else if (cnt == 5'd0) begin
                  hi_out <= prod[63:32];
                  lo_out <= prod[31:0];
                  done   <= 1'b1;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            DIV: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  // restoring step: the dividend shifts out of quo as quotient bits shift in
                  rem <= ge ? diff[31:0] : shifted[31:0];
                  quo <= {quo[30:0], ge};
                  if (cnt == 5'd0) state <= DIV_FIX;
                  else             cnt   <= cnt - 5'd1;
               end
            end
            DIV_FIX: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  lo_out <= neg_q ? -quo : quo;
                  hi_out <= neg_r ? -rem : rem;
                  done   <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (MUL_LATENCY=2); honours DIV_ZERO_TRAP_EN.
module tb_hilo_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [5:0]  alu_control;
   logic [31:0] src_a, src_b;
   logic [31:0] result_out, hi_out, lo_out;
   logic        busy, stall_req, done;
`ifdef DIV_ZERO_TRAP_EN
   logic        div_zero_exc;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   hilo_muldiv_unit #(.MUL_LATENCY(2)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .result_out(result_out), .hi_out(hi_out), .lo_out(lo_out),
      .busy(busy), .stall_req(stall_req), .done(done)
`ifdef DIV_ZERO_TRAP_EN
      , .div_zero_exc(div_zero_exc)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // drive on a falling edge, let the rising edge (E0) accept, drop start on the next falling edge
   task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; alu_control = code; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0; alu_control = 6'd0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; alu_control = 6'd0; src_a = '0; src_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_hi", hi_out, 32'h0);
      chk("rst_lo", lo_out, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      rst = 1'b0;

      // mult signed
      issue(6'd24, 32'hFFFF_FFFE, 32'h0000_0003);
      chk("mult_busy_e0", busy, 1'b1);
      chk("mult_hi_hold", hi_out, 32'h0);
      @(negedge clk);
      chk("mult_busy_e1", busy, 1'b1);
      @(negedge clk);
      chk("mult_busy_e2", busy, 1'b0);
      chk("mult_done", done, 1'b1);
      chk("mult_hi", hi_out, 32'hFFFF_FFFF);
      chk("mult_lo", lo_out, 32'hFFFF_FFFA);
      @(negedge clk);
      chk("mult_done_pulse", done, 1'b0);

      // multu
      issue(6'd25, 32'hFFFF_FFFE, 32'h0000_0003);
      repeat (2) @(negedge clk);
      chk("multu_hi", hi_out, 32'h2);
      chk("multu_lo", lo_out, 32'hFFFF_FFFA);

      // div -7/2, plus stall_req qualification while busy
      issue(6'd26, 32'hFFFF_FFF9, 32'h2);
      start = 1'b1; alu_control = 6'd0; #1;
      chk("stall_other_code", stall_req, 1'b0);
      alu_control = 6'd16; #1;
      chk("stall_mfhi", stall_req, 1'b1);
      start = 1'b0;
      repeat (32) @(negedge clk);
      chk("div_busy_e32", busy, 1'b1);
      chk("div_done_e32", done, 1'b0);
      chk("div_lo_hold", lo_out, 32'hFFFF_FFFA);
      @(negedge clk);
      chk("div_busy_e33", busy, 1'b0);
      chk("div_done", done, 1'b1);
      chk("div_lo", lo_out, 32'hFFFF_FFFD);
      chk("div_hi", hi_out, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("div_done_pulse", done, 1'b0);

      // divu 100/7 with mflo arriving at E5
      issue(6'd27, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      start = 1'b1; alu_control = 6'd18; #1;
      chk("mflo_stall", stall_req, 1'b1);
      chk("mflo_old_lo", result_out, 32'hFFFF_FFFD);
      repeat (29) @(negedge clk);
      chk("mflo_stall_drop", stall_req, 1'b0);
      chk("mflo_new_lo", result_out, 32'd14);
      chk("divu_hi", hi_out, 32'd2);
      chk("divu_done", done, 1'b1);
      start = 1'b0; alu_control = 6'd0;

      // most negative / -1
      issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
      repeat (33) @(negedge clk);
      chk("ovf_lo", lo_out, 32'h8000_0000);
      chk("ovf_hi", hi_out, 32'h0);

      // mthi then mflo
      issue(6'd17, 32'h1234, 32'h0);
      chk("mthi_hi", hi_out, 32'h1234);
      chk("mthi_lo", lo_out, 32'h8000_0000);
      chk("mthi_busy", busy, 1'b0);
      chk("mthi_no_done", done, 1'b0);
      start = 1'b1; alu_control = 6'd18; #1;
      chk("mflo_result", result_out, 32'h8000_0000);
      chk("mflo_no_stall", stall_req, 1'b0);
      start = 1'b0; alu_control = 6'd0;

      // flush at E10 of a div
      issue(6'd26, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", busy, 1'b0);
      repeat (30) @(negedge clk);
      chk("flush_no_done", done, 1'b0);
      chk("flush_hi", hi_out, 32'h1234);
      chk("flush_lo", lo_out, 32'h8000_0000);

      // flush beats start in IDLE, even for mthi
      @(negedge clk);
      start = 1'b1; flush = 1'b1; alu_control = 6'd17; src_a = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; flush = 1'b0; alu_control = 6'd0;
      chk("flush_start_hi", hi_out, 32'h1234);
      chk("flush_start_busy", busy, 1'b0);

      // divide by zero
`ifdef DIV_ZERO_TRAP_EN
      issue(6'd27, 32'd5, 32'd0);
      chk("dz_exc", div_zero_exc, 1'b1);
      chk("dz_busy", busy, 1'b0);
      @(negedge clk);
      chk("dz_exc_pulse", div_zero_exc, 1'b0);
      chk("dz_hi", hi_out, 32'h1234);
      chk("dz_lo", lo_out, 32'h8000_0000);
`else
      issue(6'd27, 32'd5, 32'd0);
      repeat (33) @(negedge clk);
      chk("dz_lo", lo_out, 32'hFFFF_FFFF);
      chk("dz_hi", hi_out, 32'd5);
`endif

      // reset at E10 of a div
      issue(6'd26, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_hi", hi_out, 32'h0);
      chk("rst_mid_lo", lo_out, 32'h0);
      chk("rst_mid_busy", busy, 1'b0);
      @(negedge clk);
      chk("rst_mid_done", done, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
